// File: rtl/reel_motion_ctrl_if.sv
// reel_motion_ctrl_if: control/status bundle between the reel sequencer and its driver
//  master drives tick/start/stop_req/dir and observes pos/level/busy/done; slave is the sequencer.
interface reel_motion_ctrl_if #(
  parameter int N_REELS = 3,
  parameter int POS_W   = 10
);
  logic                       tick;
  logic                       start;
  logic                       stop_req;
  logic                       dir;
  logic [N_REELS*POS_W-1:0]   pos;
  logic [N_REELS*2-1:0]       level;
  logic                       busy;
  logic                       done;
  modport master (output tick, start, stop_req, dir, input pos, level, busy, done);
  modport slave  (input tick, start, stop_req, dir, output pos, level, busy, done);
endinterface

// File: rtl/reel_motion_ctrl.sv
// reel_motion_ctrl: tick-driven speed/position sequencer for N slot-machine reels with staggered stops
//  clk, rst (async, active-high); bus.slave: tick/start/stop_req/dir in, pos/level/busy/done out.
module reel_motion_ctrl #(
  parameter int N_REELS  = 3,
  parameter int POS_W    = 10,
  parameter int WRAP     = 240,
  parameter int CNT_W    = 11,
  parameter int SPD_SLOW = 1,
  parameter int SPD_MID  = 2,
  parameter int SPD_FAST = 3,
  parameter int T_MID    = 240,
  parameter int T_FAST   = 360,
  parameter int T_DECEL  = 600,
  parameter int STAGGER  = 160,
  parameter int T_STEP   = 120
) (
  input logic clk,
  input logic rst,
  reel_motion_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SLOW_A = 3'd1, MID_A = 3'd2, FAST = 3'd3, MID_D = 3'd4, SLOW_D = 3'd5;
  localparam logic [POS_W:0] W = (POS_W+1)'(WRAP);
  logic [N_REELS-1:0][2:0]       phase_q, phase_d;
  logic [N_REELS-1:0][POS_W-1:0] pos_q, pos_d;
  logic [N_REELS-1:0][1:0]       level_q, level_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d, n;
  logic                          busy_q, busy_d, done_q, done_d;
  function automatic logic [1:0] lvl(input logic [2:0] ph);
    return ph == IDLE ? 2'd0 : (ph == SLOW_A || ph == SLOW_D) ? 2'd1 : ph == FAST ? 2'd3 : 2'd2;
  endfunction
  // Step is computed one bit wider so the forward sum and reverse borrow are both visible.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic [2:0] ph, input logic fwd);
    logic [POS_W:0] s, sum, dif;
    s   = (POS_W+1)'(lvl(ph) == 2'd1 ? SPD_SLOW : lvl(ph) == 2'd2 ? SPD_MID : lvl(ph) == 2'd3 ? SPD_FAST : 0);
    sum = {1'b0, p} + s;
    dif = {1'b0, p} - s;
    return fwd ? (sum >= W ? POS_W'(sum - W) : sum[POS_W-1:0])
               : ({1'b0, p} < s ? POS_W'(dif + W) : dif[POS_W-1:0]);
  endfunction
  function automatic logic [CNT_W-1:0] t_dec(input int i, input int k);
    return CNT_W'(T_DECEL + i*STAGGER + k*T_STEP);
  endfunction
  always_comb begin
    n       = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    if (bus.start && !busy_q) begin
      cnt_d = '0;
      for (int i = 0; i < N_REELS; i++) phase_d[i] = SLOW_A;
    end else if (busy_q) begin
      if (bus.tick) begin
        cnt_d = n;
        for (int i = 0; i < N_REELS; i++) begin
          pos_d[i]   = step_pos(pos_q[i], phase_q[i], bus.dir);
          phase_d[i] = (n == CNT_W'(T_MID)  && phase_q[i] == SLOW_A) ? MID_A  :
                       (n == CNT_W'(T_FAST) && phase_q[i] == MID_A)  ? FAST   :
                       (n == t_dec(i, 0)    && phase_q[i] == FAST)   ? MID_D  :
                       (n == t_dec(i, 1)    && phase_q[i] == MID_D)  ? SLOW_D :
                       (n == t_dec(i, 2)    && phase_q[i] == SLOW_D) ? IDLE   : phase_q[i];
        end
      end
      // Early stop jumps the schedule to reel 0's decel point; pos above still moved on the old level.
      if (bus.stop_req && cnt_q < CNT_W'(T_DECEL)) begin
        cnt_d = CNT_W'(T_DECEL);
        for (int i = 0; i < N_REELS; i++) phase_d[i] = i == 0 ? MID_D : FAST;
      end
    end
    busy_d = 1'b0;
    for (int i = 0; i < N_REELS; i++) begin
      level_d[i] = lvl(phase_d[i]);
      busy_d     = busy_d | (phase_d[i] != IDLE);
    end
    done_d = busy_q && !busy_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase_q <= '0;
      pos_q   <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign bus.pos   = pos_q;
  assign bus.level = level_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_reel_motion_ctrl.sv
// tb_reel_motion_ctrl: directed checks of the reel sequencer (3-reel default and 5-reel stagger-40 instance)
module tb_reel_motion_ctrl;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0, stop_req = 1'b0, dir = 1'b1;
  int total = 0, passes = 0, fails = 0;
  reel_motion_ctrl_if #(.N_REELS(3), .POS_W(10)) b3 ();
  reel_motion_ctrl_if #(.N_REELS(5), .POS_W(10)) b5 ();
  assign b3.tick = tick;
  assign b3.start = start;
  assign b3.stop_req = stop_req;
  assign b3.dir = dir;
  assign b5.tick = tick;
  assign b5.start = start;
  assign b5.stop_req = stop_req;
  assign b5.dir = dir;
  reel_motion_ctrl u3 (.clk(clk), .rst(rst), .bus(b3));
  reel_motion_ctrl #(.N_REELS(5), .STAGGER(40)) u5 (.clk(clk), .rst(rst), .bus(b5));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic tk, input logic st, input logic sr);
    @(negedge clk);
    tick = tk;
    start = st;
    stop_req = sr;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int k);
    repeat (k) step(1'b1, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b0;
    start = 1'b0;
    stop_req = 1'b0;
    dir = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_pos", b3.pos, 0);
    chk("rst_level", b3.level, 0);
    chk("rst_busy", b3.busy, 0);
    chk("rst_done", b3.done, 0);
    do_reset();
    // full forward run, with the 5-reel instance running in lockstep
    step(1'b0, 1'b1, 1'b0);
    chk("start_busy", b3.busy, 1);
    chk("start_level", b3.level, 6'b010101);
    run(239);
    chk("t239_lv0", b3.level[1:0], 1);
    chk("t239_pos0", b3.pos[9:0], 239);
    run(1);
    chk("t240_lv0", b3.level[1:0], 2);
    run(120);
    chk("t360_lv0", b3.level[1:0], 3);
    run(240);
    chk("t600_lv0", b3.level[1:0], 2);
    chk("t600_lv1", b3.level[3:2], 3);
    run(120);
    chk("t720_lv0", b3.level[1:0], 1);
    run(39);
    chk("n5_t759_lv4", b5.level[9:8], 3);
    run(1);
    chk("n5_t760_lv4", b5.level[9:8], 2);
    run(80);
    chk("t840_lv0", b3.level[1:0], 0);
    chk("t840_lv1", b3.level[3:2], 2);
    run(159);
    chk("n5_t999_busy", b5.busy, 1);
    chk("n5_t999_done", b5.done, 0);
    run(1);
    chk("n5_t1000_busy", b5.busy, 0);
    chk("n5_t1000_done", b5.done, 1);
    run(1);
    chk("n5_t1001_done", b5.done, 0);
    run(158);
    chk("t1159_busy", b3.busy, 1);
    chk("t1159_done", b3.done, 0);
    run(1);
    chk("t1160_busy", b3.busy, 0);
    chk("t1160_done", b3.done, 1);
    chk("t1160_pos", b3.pos, {10'd120, 10'd120, 10'd120});
    run(1);
    chk("idle_done", b3.done, 0);
    chk("idle_pos", b3.pos, {10'd120, 10'd120, 10'd120});
    // reverse then forward wrap
    do_reset();
    dir = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    run(1);
    chk("rev_wrap", b3.pos, {10'd239, 10'd239, 10'd239});
    dir = 1'b1;
    run(1);
    chk("fwd_wrap", b3.pos, 0);
    // early stop
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run(100);
    chk("es_pos0", b3.pos[9:0], 100);
    step(1'b0, 1'b0, 1'b1);
    chk("es_level", b3.level, 6'b111110);
    chk("es_pos_hold", b3.pos[9:0], 100);
    run(559);
    chk("es_busy559", b3.busy, 1);
    run(1);
    chk("es_busy560", b3.busy, 0);
    chk("es_done", b3.done, 1);
    chk("es_pos", b3.pos, {10'd220, 10'd220, 10'd220});
    // ignored inputs
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run(300);
    step(1'b0, 1'b1, 1'b0);
    chk("ig_start_level", b3.level, 6'b101010);
    chk("ig_start_pos0", b3.pos[9:0], 120);
    repeat (50) step(1'b0, 1'b0, 1'b0);
    chk("ig_freeze_pos0", b3.pos[9:0], 120);
    run(60);
    chk("ig_t360_level", b3.level, 6'b111111);
    chk("ig_t360_pos0", b3.pos[9:0], 0);
    run(340);
    step(1'b0, 1'b0, 1'b1);
    chk("ig_stop_level", b3.level, 6'b111110);
    chk("ig_stop_pos0", b3.pos[9:0], 200);
    run(20);
    chk("ig_t720_level", b3.level, 6'b111101);
    // asynchronous reset mid-run
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    run(300);
    #2 rst = 1'b1;
    #1;
    chk("ar_pos", b3.pos, 0);
    chk("ar_level", b3.level, 0);
    chk("ar_busy", b3.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    run(239);
    chk("ar_pos239", b3.pos, {10'd239, 10'd239, 10'd239});
    chk("ar_lv239", b3.level, 6'b010101);
    run(1);
    chk("ar_lv240", b3.level, 6'b101010);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
